lsu_axil_master: RTL and testbench

Load/store initiator that takes one load or store at a time from the core's execute stage and drives an AXI4-Lite master port toward data memory. It is the requesting end of the data-memory interface. It handles:
- byte-lane placement and write strobes,
- load extraction with sign or zero extension,
- misalignment and opcode checks,
- bus error reporting.

It sits between the core's EX/MEM logic and the memory/crossbar responder.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/lsu_axil_master_if.sv | 35 +++
 rtl/lsu_lane.sv | 38 +++
 rtl/lsu_axil_master.sv | 146 ++++++++++++++
 tb/tb_lsu_axil_master.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared MemOp codes, FSM states and AXI response constants for the LSU
package mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B,
    ST_RESP
  } lsu_state_t;

  // True when the request can never reach the bus: unknown MemOp or a misaligned halfword/word.
  function automatic logic memop_bad(input logic [2:0] memop, input logic [1:0] off);
    case (memop)
      MEMOP_B, MEMOP_BU: memop_bad = 1'b0;
      MEMOP_H, MEMOP_HU: memop_bad = off[0];
      MEMOP_W:           memop_bad = (off != 2'b00);
      default:           memop_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_axil_master_if.sv
// rtl/lsu_axil_master_if.sv - AXI4-Lite channel bundle between the LSU and data memory
interface lsu_axil_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane placement for stores and extraction/extension for loads
module lsu_lane
  import mem_pkg::*;
(
  input  logic [2:0]  memop,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wstrb,
  output logic [31:0] ld_ext
);

  logic [31:0] ld_shifted;

  // Store side: BU/HU share B/H lane rules because only memop[1:0] selects the size.
  always_comb begin
    st_wdata = st_data << {off, 3'b000};
    case (memop[1:0])
      2'b00:   st_wstrb = 4'b0001 << off;
      2'b01:   st_wstrb = 4'b0011 << off;
      default: st_wstrb = 4'b1111;
    endcase
  end

  // Load side: bring the addressed lane down to bit 0, then extend per MemOp.
  always_comb begin
    ld_shifted = ld_data >> {off, 3'b000};
    case (memop)
      MEMOP_B:  ld_ext = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MEMOP_H:  ld_ext = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      MEMOP_BU: ld_ext = {24'd0, ld_shifted[7:0]};
      MEMOP_HU: ld_ext = {16'd0, ld_shifted[15:0]};
      default:  ld_ext = ld_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_axil_master.sv
// rtl/lsu_axil_master.sv - single-outstanding load/store initiator on an AXI4-Lite master port
module lsu_axil_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_memop,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  lsu_axil_master_if.master axi
);

  lsu_state_t  state;
  logic [2:0]  memop_q;
  logic [1:0]  off_q;

  logic [2:0]  lane_memop;
  logic [1:0]  lane_off;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_ld;

  // In IDLE the lane works on the live request so store data can be registered at accept;
  // afterwards it works on the latched request to extract the returning load data.
  always_comb begin
    lane_memop = (state == ST_IDLE) ? req_memop     : memop_q;
    lane_off   = (state == ST_IDLE) ? req_addr[1:0] : off_q;
  end

  lsu_lane u_lane (
    .memop    (lane_memop),
    .off      (lane_off),
    .st_data  (req_wdata),
    .ld_data  (axi.rdata),
    .st_wdata (lane_wdata),
    .st_wstrb (lane_wstrb),
    .ld_ext   (lane_ld)
  );

  // Transaction sequencer; every bus and response output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      memop_q     <= '0;
      off_q       <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.bready  <= 1'b0;
      axi.arvalid <= 1'b0;
      axi.araddr  <= '0;
      axi.rready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            memop_q   <= req_memop;
            off_q     <= req_addr[1:0];
            if (memop_bad(req_memop, req_addr[1:0])) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= ST_RESP;
            end else if (req_wen) begin
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              axi.awaddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              axi.wdata   <= lane_wdata;
              axi.wstrb   <= lane_wstrb;
              state       <= ST_AWW;
            end else begin
              axi.arvalid <= 1'b1;
              axi.araddr  <= {req_addr[ADDR_W-1:2], 2'b00};
              state       <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= ST_R;
          end
        end
        ST_R: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            resp_valid <= 1'b1;
            if (axi.rresp != AXI_RESP_OKAY) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              resp_err   <= 1'b0;
              resp_rdata <= lane_ld;
            end
            state <= ST_RESP;
          end
        end
        ST_AWW: begin
          if (axi.awvalid && axi.awready) axi.awvalid <= 1'b0;
          if (axi.wvalid && axi.wready)   axi.wvalid  <= 1'b0;
          // A channel counts as done if it already dropped or hands off this cycle.
          if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
            axi.bready <= 1'b1;
            state      <= ST_B;
          end
        end
        ST_B: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= (axi.bresp != AXI_RESP_OKAY);
            resp_rdata <= '0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// tb/tb_lsu_axil_master.sv - self-checking bench for lsu_axil_master with an AXI4-Lite responder
module tb_lsu_axil_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_memop;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  lsu_axil_master_if axi ();

  lsu_axil_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_memop  (req_memop),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations from the most recent transaction.
  int          g_pulses, g_cycle, g_hold, g_dup;
  logic        g_bus, g_timeout, g_err;
  logic [31:0] g_rdata, g_araddr, g_awaddr, g_wdata;
  logic [3:0]  g_wstrb;

  // Reference model, written from the MemOp rules rather than from any RTL structure.
  function automatic int size_of(input logic [2:0] m);
    case (m)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic exp_pre_err(input logic [2:0] m, input logic [31:0] a);
    int sz;
    sz = size_of(m);
    return (sz == 0) || ((a % sz) != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] m, input int off, input logic [31:0] d);
    longint v;
    v = longint'(d) / (longint'(1) << (8 * off));
    if (m == 3'd0 || m == 3'd4) v = v % 256;
    if (m == 3'd1 || m == 3'd5) v = v % 65536;
    if (m == 3'd0 && v >= 128)   v = v - 256;
    if (m == 3'd1 && v >= 32768) v = v - 65536;
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] m, input int off);
    logic [3:0] s;
    s = 4'b0000;
    for (int i = 0; i < size_of(m); i++) s[off + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input int off);
    longint v;
    v = (longint'(d) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
    return v[31:0];
  endfunction

  task automatic idle_responder();
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
  endtask

  // Issues one request and plays the memory side with the given per-channel delays.
  // Cycle 0 is the accept cycle; g_cycle is the cycle in which resp_valid was seen.
  task automatic run_txn(input logic wen, input logic [2:0] memop, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic [1:0] resp,
                         input int ar_dly, input int aw_dly, input int w_dly, input int b_dly,
                         input int r_dly);
    int   cyc, ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt;
    logic ar_done, aw_done, w_done, b_done, r_done;
    logic ar_hs, aw_hs, w_hs, b_hs, r_hs;
    logic p_ar, p_aw, p_w;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
    ar_done = 0; aw_done = 0; w_done = 0; b_done = 0; r_done = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0; r_hs = 0;
    p_ar = 0; p_aw = 0; p_w = 0;
    g_pulses = 0; g_cycle = -1; g_hold = 0; g_dup = 0; g_bus = 0; g_timeout = 0;
    g_err = 0; g_rdata = 0; g_araddr = 0; g_awaddr = 0; g_wdata = 0; g_wstrb = 0;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_wen = wen; req_memop = memop; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen = 1'($urandom); req_memop = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 1;
    while (1) begin
      if (ar_hs) ar_done = 1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (b_hs)  b_done  = 1;
      if (r_hs)  r_done  = 1;
      if (p_ar && !ar_hs && !axi.arvalid) g_hold++;
      if (p_aw && !aw_hs && !axi.awvalid) g_hold++;
      if (p_w  && !w_hs  && !axi.wvalid)  g_hold++;
      if ((ar_done && axi.arvalid) || (aw_done && axi.awvalid) || (w_done && axi.wvalid)) g_dup++;
      if (axi.arvalid || axi.awvalid || axi.wvalid) g_bus = 1;
      if (axi.arvalid) g_araddr = axi.araddr;
      if (axi.awvalid) g_awaddr = axi.awaddr;
      if (axi.wvalid) begin g_wdata = axi.wdata; g_wstrb = axi.wstrb; end
      if (resp_valid) begin
        g_pulses++;
        if (g_pulses == 1) begin g_cycle = cyc; g_rdata = resp_rdata; g_err = resp_err; end
      end
      if (g_pulses > 0 && cyc >= g_cycle + 2) break;
      if (cyc >= 60) begin g_timeout = 1; break; end
      axi.arready = axi.arvalid && !ar_done && (ar_cnt >= ar_dly);
      if (axi.arvalid && !ar_done) ar_cnt++;
      axi.awready = axi.awvalid && !aw_done && (aw_cnt >= aw_dly);
      if (axi.awvalid && !aw_done) aw_cnt++;
      axi.wready = axi.wvalid && !w_done && (w_cnt >= w_dly);
      if (axi.wvalid && !w_done) w_cnt++;
      axi.rvalid = ar_done && !r_done && (r_cnt >= r_dly);
      if (ar_done && !r_done) r_cnt++;
      axi.rdata = rdata; axi.rresp = resp;
      axi.bvalid = aw_done && w_done && !b_done && (b_cnt >= b_dly);
      if (aw_done && w_done && !b_done) b_cnt++;
      axi.bresp = resp;
      ar_hs = axi.arvalid && axi.arready;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid && axi.wready;
      r_hs  = axi.rvalid && axi.rready;
      b_hs  = axi.bvalid && axi.bready;
      p_ar = axi.arvalid; p_aw = axi.awvalid; p_w = axi.wvalid;
      @(posedge clk); #1;
      cyc++;
    end
    idle_responder();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_memop = 3'd0; req_addr = 0; req_wdata = 0;
    idle_responder();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else n_pass++;
    n_checks++;
    if ({resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready} !== 7'd0)
      $display("FAIL reset_valids got=%b exp=0", {resp_valid, resp_err, axi.arvalid, axi.awvalid, axi.wvalid, axi.bready, axi.rready});
    else n_pass++;
    n_checks++;
    if ({resp_rdata, axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== 132'd0)
      $display("FAIL reset_data got=%h %h %h %h %h exp=0", resp_rdata, axi.araddr, axi.awaddr, axi.wdata, axi.wstrb);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_loads();
    logic [31:0] d;
    run_txn(1'b0, 3'b000, 32'h8000_0003, 32'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_araddr !== 32'h8000_0000) $display("FAIL lb_araddr got=%h exp=80000000", g_araddr); else n_pass++;
    n_checks++; if (g_rdata !== 32'hFFFF_FF80 || g_err !== 1'b0) $display("FAIL lb_data got=%h err=%b exp=ffffff80 err=0", g_rdata, g_err); else n_pass++;
    n_checks++; if (g_cycle !== 3) $display("FAIL lb_latency got=%0d exp=3", g_cycle); else n_pass++;
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'd0, 32'hBEEF_0000, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_rdata !== 32'h0000_BEEF) $display("FAIL lhu_data got=%h exp=0000beef", g_rdata); else n_pass++;
    d = $urandom;
    run_txn(1'b0, 3'b010, 32'h8000_0004, 32'd0, d, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_rdata !== d || g_araddr !== 32'h8000_0004) $display("FAIL lw_data got=%h addr=%h exp=%h addr=80000004", g_rdata, g_araddr, d); else n_pass++;
  endtask

  task automatic test_stores();
    run_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'd0, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_wstrb !== 4'b0010 || g_wdata[15:8] !== 8'hAB) $display("FAIL sb_lane got strb=%b byte=%h exp strb=0010 byte=ab", g_wstrb, g_wdata[15:8]); else n_pass++;
    n_checks++; if (g_awaddr !== 32'h8000_0000) $display("FAIL sb_awaddr got=%h exp=80000000", g_awaddr); else n_pass++;
    n_checks++; if (g_cycle !== 3 || g_err !== 1'b0 || g_rdata !== 32'd0) $display("FAIL sb_resp got cyc=%0d err=%b rdata=%h exp cyc=3 err=0 rdata=0", g_cycle, g_err, g_rdata); else n_pass++;
    run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'd0, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_wstrb !== 4'b1100 || g_wdata !== 32'h1234_0000) $display("FAIL sh_lane got strb=%b wdata=%h exp strb=1100 wdata=12340000", g_wstrb, g_wdata); else n_pass++;
  endtask

  task automatic test_handshake_orders();
    // Columns: wen, ar_dly, aw_dly, w_dly, expected resp cycle.
    int tbl [4][5] = '{'{0, 3, 0, 0, 6}, '{1, 0, 2, 0, 5}, '{1, 0, 0, 2, 5}, '{1, 0, 1, 1, 4}};
    for (int k = 0; k < 4; k++) begin
      run_txn(1'(tbl[k][0]), 3'b010, 32'h8000_0100, $urandom, $urandom, 2'b00,
              tbl[k][1], tbl[k][2], tbl[k][3], 0, 0);
      n_checks++;
      if (g_pulses !== 1 || g_hold !== 0 || g_dup !== 0)
        $display("FAIL order%0d_handshake got pulses=%0d hold=%0d dup=%0d exp 1/0/0", k, g_pulses, g_hold, g_dup);
      else n_pass++;
      n_checks++; if (g_cycle !== tbl[k][4]) $display("FAIL order%0d_latency got=%0d exp=%0d", k, g_cycle, tbl[k][4]); else n_pass++;
    end
  endtask

  task automatic test_errors();
    run_txn(1'b0, 3'b010, 32'h8000_0002, 32'd0, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_cycle !== 1 || g_err !== 1'b1 || g_bus !== 1'b0 || g_pulses !== 1) $display("FAIL misaligned got cyc=%0d err=%b bus=%b pulses=%0d exp 1/1/0/1", g_cycle, g_err, g_bus, g_pulses); else n_pass++;
    run_txn(1'b0, 3'b111, 32'h8000_0000, 32'd0, 32'h1111_1111, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_cycle !== 1 || g_err !== 1'b1 || g_bus !== 1'b0 || g_rdata !== 32'd0) $display("FAIL illegal_memop got cyc=%0d err=%b bus=%b rdata=%h exp 1/1/0/0", g_cycle, g_err, g_bus, g_rdata); else n_pass++;
    run_txn(1'b0, 3'b010, 32'h8000_0008, 32'd0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0);
    n_checks++; if (g_err !== 1'b1 || g_rdata !== 32'd0) $display("FAIL rresp_err got err=%b rdata=%h exp err=1 rdata=0", g_err, g_rdata); else n_pass++;
    run_txn(1'b1, 3'b010, 32'h8000_0008, 32'h5555_AAAA, 32'd0, 2'b11, 0, 0, 0, 0, 0);
    n_checks++; if (g_err !== 1'b1 || g_rdata !== 32'd0) $display("FAIL bresp_err got err=%b rdata=%h exp err=1 rdata=0", g_err, g_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    @(posedge clk); #1;
    idle_responder();
    req_valid = 1'b1; req_wen = 1'b0; req_memop = 3'b010; req_addr = 32'h8000_0010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (axi.arvalid !== 1'b1) $display("FAIL mid_arvalid_held got=%b exp=1", axi.arvalid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (axi.arvalid !== 1'b0) $display("FAIL mid_arvalid_async_drop got=%b exp=0", axi.arvalid); else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) $display("FAIL mid_after_release got ready=%b rv=%b exp 1/0", req_ready, resp_valid); else n_pass++;
    d = $urandom;
    run_txn(1'b0, 3'b001, 32'h8000_0012, 32'd0, d, 2'b00, 0, 0, 0, 0, 0);
    n_checks++; if (g_cycle !== 3 || g_rdata !== exp_load(3'b001, 2, d) || g_err !== 1'b0) $display("FAIL mid_followup got cyc=%0d rdata=%h err=%b exp cyc=3 rdata=%h err=0", g_cycle, g_rdata, g_err, exp_load(3'b001, 2, d)); else n_pass++;
  endtask

  task automatic test_random();
    logic        wen, pre, e_err;
    logic [2:0]  m;
    logic [31:0] a, wd, rd, e_rdata;
    logic [1:0]  rsp;
    int          ard, awd, wdl, bd, rdl, off, e_cyc;
    for (int it = 0; it < 40; it++) begin
      wen = 1'($urandom); m = 3'($urandom); a = $urandom; wd = $urandom; rd = $urandom;
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ard = $urandom_range(0, 3); awd = $urandom_range(0, 3); wdl = $urandom_range(0, 3);
      bd = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      off = a % 4;
      pre = exp_pre_err(m, a);
      e_err = pre || (rsp != 2'b00);
      e_rdata = (e_err || wen) ? 32'd0 : exp_load(m, off, rd);
      if (pre) e_cyc = 1;
      else if (wen) e_cyc = 3 + ((awd > wdl) ? awd : wdl) + bd;
      else e_cyc = 3 + ard + rdl;
      run_txn(wen, m, a, wd, rd, rsp, ard, awd, wdl, bd, rdl);
      n_checks++;
      if (g_timeout !== 1'b0 || g_pulses !== 1 || g_hold !== 0 || g_dup !== 0)
        $display("FAIL rnd%0d_protocol got to=%b pulses=%0d hold=%0d dup=%0d exp 0/1/0/0", it, g_timeout, g_pulses, g_hold, g_dup);
      else n_pass++;
      n_checks++;
      if (g_err !== e_err || g_rdata !== e_rdata || g_cycle !== e_cyc)
        $display("FAIL rnd%0d_resp got err=%b rdata=%h cyc=%0d exp err=%b rdata=%h cyc=%0d", it, g_err, g_rdata, g_cycle, e_err, e_rdata, e_cyc);
      else n_pass++;
      n_checks++;
      if (g_bus !== !pre) $display("FAIL rnd%0d_bus got=%b exp=%b", it, g_bus, !pre); else n_pass++;
      if (!pre && wen) begin
        n_checks++;
        if (g_awaddr !== {a[31:2], 2'b00} || g_wstrb !== exp_strb(m, off) || g_wdata !== exp_wdata(wd, off))
          $display("FAIL rnd%0d_store got addr=%h strb=%b wdata=%h exp addr=%h strb=%b wdata=%h", it, g_awaddr, g_wstrb, g_wdata, {a[31:2], 2'b00}, exp_strb(m, off), exp_wdata(wd, off));
        else n_pass++;
      end
      if (!pre && !wen) begin
        n_checks++;
        if (g_araddr !== {a[31:2], 2'b00}) $display("FAIL rnd%0d_araddr got=%h exp=%h", it, g_araddr, {a[31:2], 2'b00}); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_handshake_orders();
    test_errors();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1);
  end

endmodule
